regfile_dump: RTL and testbench

Read-side debug unit for the processor register file. On a start pulse it walks registers FIRST_REG..LAST_REG through a spare register-file read port and streams each 32-bit value out over a valid/ready handshake, tagged with its index. It also accumulates a 32-bit wrap-around sum of the streamed words. It sits beside the register file and feeds the test harness or debug link, and it never writes the register file.

---
 rtl/regfile_dump.sv | 122 ++++++++++++
 tb/tb_regfile_dump.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks register-file entries FIRST_REG..LAST_REG through a
// spare read port and streams each word out, tagged with its index. It also
// keeps a 32-bit wrap-around sum of the accepted words. It never writes the
// register file.
//
// Output handshake: a word transfers on any posedge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data and out_idx (and the read address AD) hold steady. out_valid
// drops after the transfer.
module regfile_dump #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic [4:0]  AD,
   input  logic [31:0] RD,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_idx,
   output logic        busy,
   output logic        done,
   output logic [31:0] checksum,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [4:0] LP_FIRST = 5'(FIRST_REG);
   localparam logic [4:0] LP_LAST  = 5'(LAST_REG);

   state_t      r_state;
   logic [4:0]  r_idx;
   logic        r_out_valid;
   logic [31:0] r_out_data;
   logic [4:0]  r_out_idx;
   logic        r_done;
   logic [31:0] r_checksum;
   logic        w_accept;

   // A word is taken whenever the held word meets a ready consumer.
   assign w_accept = (r_state == S_HOLD) && out_ready;

   // Read address follows the walk index in every state, so it holds steady during stalls.
   assign AD        = r_idx;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_out_idx;
   assign done      = r_done;
   assign checksum  = r_checksum;
   assign busy      = (r_state == S_READ) || (r_state == S_HOLD);
   assign dbg_state = r_state;

   // Dump sequencer: IDLE -> READ -> HOLD -> (READ ... | DONE) -> IDLE, with abort back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= 5'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= 32'd0;
         r_out_idx   <= 5'd0;
         r_done      <= 1'b0;
         r_checksum  <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx      <= LP_FIRST;
                  r_checksum <= 32'd0;
                  r_state    <= S_READ;
               end
            end
            S_READ: begin
               if (abort) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  // RD is captured here; later writes to this entry do not reach the held word.
                  r_out_data  <= RD;
                  r_out_idx   <= r_idx;
                  r_out_valid <= 1'b1;
                  r_state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (w_accept) begin
                  r_checksum  <= r_checksum + r_out_data;
                  r_out_valid <= 1'b0;
               end
               if (abort) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end else if (w_accept) begin
                  if (r_idx == LP_LAST) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_idx   <= r_idx + 5'd1;
                     r_state <= S_READ;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file feeds two instances
// (full 0..31 walk and a single-register 10..10 walk). Each dump is checked
// against an expected word queue built from the register contents at start.
module tb_regfile_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        ready;
  logic        sel;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] mem [32];

  logic [4:0]  ad_a, ad_b, idx_a, idx_b;
  logic [31:0] rd_a, rd_b, data_a, data_b, csum_a, csum_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [1:0]  st_a, st_b;

  logic [4:0]  ad, idx;
  logic [31:0] data, csum;
  logic        valid, busy, done_s;

  int total;
  int bad;

  regfile_dump #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .rst(rst), .start(start && !sel), .abort(abort && !sel),
    .AD(ad_a), .RD(rd_a), .out_valid(valid_a), .out_ready(ready),
    .out_data(data_a), .out_idx(idx_a), .busy(busy_a), .done(done_a),
    .checksum(csum_a), .dbg_state(st_a)
  );

  regfile_dump #(.FIRST_REG(10), .LAST_REG(10)) dut_single (
    .clk(clk), .rst(rst), .start(start && sel), .abort(abort && sel),
    .AD(ad_b), .RD(rd_b), .out_valid(valid_b), .out_ready(ready),
    .out_data(data_b), .out_idx(idx_b), .busy(busy_b), .done(done_b),
    .checksum(csum_b), .dbg_state(st_b)
  );

  // Register file: entry 0 reads as zero, writes commit on posedge.
  assign rd_a = (ad_a == 5'd0) ? 32'd0 : mem[ad_a];
  assign rd_b = (ad_b == 5'd0) ? 32'd0 : mem[ad_b];
  always @(posedge clk) if (we) mem[wa] <= wd;

  assign ad     = sel ? ad_b    : ad_a;
  assign idx    = sel ? idx_b   : idx_a;
  assign data   = sel ? data_b  : data_a;
  assign csum   = sel ? csum_b  : csum_a;
  assign valid  = sel ? valid_b : valid_a;
  assign busy   = sel ? busy_b  : busy_a;
  assign done_s = sel ? done_b  : done_a;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [31:0] v);
    we = 1'b1; wa = 5'(i); wd = v;
    @(negedge clk);
    we = 1'b0;
  endtask

  // One dump from IDLE. rmode 0: ready always high, 1: random ready.
  // abort_word >= 0 aborts while that word is held with ready low.
  // wr_idx >= 0 writes that register during its READ and HOLD cycles.
  task automatic run_dump(input logic s, input int first, input int last,
                          input int rmode, input int abort_word, input int wr_idx);
    logic [31:0] exp_q[$];
    logic [4:0]  eidx_q[$];
    logic [31:0] sum, hold_d, ew;
    logic [4:0]  hold_i;
    bit          prev_stall, fin, aborted;
    int          k, nacc, wr_phase, last_acc;
    bit          exact;
    sum = 0; hold_d = 0; hold_i = 0; prev_stall = 0; fin = 0; aborted = 0;
    k = 0; nacc = 0; wr_phase = 0; last_acc = 0;
    exact = (rmode == 0) && (wr_idx < 0) && (abort_word < 0);
    sel = s;
    for (int i = first; i <= last; i++) begin
      exp_q.push_back((i == 0) ? 32'd0 : mem[i]);
      eidx_q.push_back(5'(i));
    end
    start = 1'b1;
    ready = 1'b0;
    while (!fin && k < 400) begin
      @(negedge clk);
      k++;
      start = 1'b0; we = 1'b0; abort = 1'b0;
      if (k == 1) begin
        chk("first_ad", 32'(ad), 32'(first));
        chk("start_busy", 32'(busy), 1);
        chk("start_csum_clear", csum, 0);
      end
      if (aborted) begin
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_no_done", 32'(done_s), 0);
        chk("abort_csum", csum, sum);
        fin = 1;
      end else if (done_s) begin
        chk("done_valid_excl", 32'(valid), 0);
        chk("done_after_accept", 32'(k), 32'(last_acc + 1));
        if (exact) chk("done_cycle", 32'(k), 32'(2 * (last - first + 1) + 1));
        chk("done_csum", csum, sum);
        chk("words_left", 32'(exp_q.size()), 0);
        fin = 1;
      end else if (valid) begin
        chk("hold_busy", 32'(busy), 1);
        if (prev_stall) begin
          chk("stall_data", data, hold_d);
          chk("stall_idx", 32'(idx), 32'(hold_i));
          chk("stall_ad", 32'(ad), 32'(hold_i));
        end
        hold_d = data; hold_i = idx;
        ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (wr_phase == 1) begin
          ready = 1'b0; we = 1'b1; wa = 5'(wr_idx); wd = 32'h12345678; wr_phase = 2;
        end else if (wr_phase == 2) begin
          ready = 1'b1; wr_phase = 3;
        end
        if (abort_word >= 0 && nacc == abort_word) begin
          ready = 1'b0; abort = 1'b1; aborted = 1;
        end
        if (ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_word", 32'(idx), 32'hFFFFFFFF);
          end else begin
            ew = exp_q.pop_front();
            chk("word_data", data, ew);
            chk("word_idx", 32'(idx), 32'(eidx_q.pop_front()));
            sum = sum + ew;
          end
          if (exact) chk("word_spacing", 32'(k), 32'(2 + 2 * nacc));
          nacc++;
          last_acc = k;
        end
        prev_stall = !ready;
      end else begin
        prev_stall = 0;
        if (wr_idx >= 0 && wr_phase == 0 && busy && ad == 5'(wr_idx)) begin
          we = 1'b1; wa = 5'(wr_idx); wd = 32'hCAFEF00D; wr_phase = 1;
        end
      end
    end
    if (!fin) chk("dump_timeout", 32'(k), 0);
    ready = 1'b0; abort = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("back_idle_busy", 32'(busy), 0);
    chk("done_one_cycle", 32'(done_s), 0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; sel = 1'b0;
    we = 1'b0; wa = 5'd0; wd = 32'd0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_data", data_a, 0);
    chk("rst_idx", 32'(idx_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_csum", csum_a, 0);
    chk("rst_ad", 32'(ad_a), 0);
    chk("rst_state", 32'(st_a), 0);
    rst = 1'b0;

    // preload register i = i*0x11111111, with junk in entry 0 that must read as zero
    load(0, 32'hA5A5A5A5);
    for (int i = 1; i < 32; i++) load(i, 32'(i) * 32'h11111111);

    // full dump, ready always high
    run_dump(1'b0, 0, 31, 0, -1, -1);
    chk("full_sum_const", csum_a, 32'h111110F0);

    // full dump, random ready
    run_dump(1'b0, 0, 31, 1, -1, -1);
    chk("rand_ready_sum_const", csum_a, 32'h111110F0);

    // single-register dump
    load(10, 32'hDEADBEEF);
    sel = 1'b1;
    run_dump(1'b1, 10, 10, 0, -1, -1);
    chk("single_sum", csum_b, 32'hDEADBEEF);
    chk("single_idx", 32'(idx_b), 10);

    // writes to register 5 during its READ and HOLD must not alter the held word
    run_dump(1'b0, 0, 31, 0, -1, 5);

    // abort at the third HOLD with ready low, then restart
    run_dump(1'b0, 0, 31, 0, 2, -1);
    chk("abort_sum_const", csum_a, 32'h11111111);
    run_dump(1'b0, 0, 31, 1, -1, -1);

    // random register contents, random ready
    for (int i = 0; i < 32; i++) load(i, $urandom);
    run_dump(1'b0, 0, 31, 1, -1, -1);

    // start re-pulsed while busy, then reset mid-dump
    sel = 1'b0; ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_busy", 32'(busy_a), 1);
    @(negedge clk);
    chk("restart_ignored_valid", 32'(valid_a), 1);
    chk("restart_ignored_idx", 32'(idx_a), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ready = 1'b0;
    chk("midrst_valid", 32'(valid_a), 0);
    chk("midrst_data", data_a, 0);
    chk("midrst_idx", 32'(idx_a), 0);
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_csum", csum_a, 0);
    chk("midrst_ad", 32'(ad_a), 0);
    chk("midrst_state", 32'(st_a), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done_a), 0);
      chk("midrst_stay_idle", 32'(busy_a), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
